// File: rtl/rom_load_pkg.sv
// rom_load_pkg: shared types and constants for the ROM download scheduler
package rom_load_pkg;
  typedef enum logic [1:0] {REG_CPU, REG_SND, REG_GFX} rom_region_t;
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, HOLD} load_state_t;
  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_MOD = 8'd1;
  localparam logic [7:0] IDX_DIP = 8'd254;
  localparam logic [24:0] R0_END_DEF = 25'h0C000;
  localparam logic [24:0] R1_END_DEF = 25'h0D000;
  localparam logic [24:0] R2_END_DEF = 25'h15000;
endpackage

// File: rtl/rom_load_skid.sv
// rom_load_skid: one-entry valid/ready buffer; accepts only when empty
module rom_load_skid #(
  parameter int W = 26
) (
  input  logic         clk_sys,
  input  logic         reset_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data
);
  // hold one entry until the consumer takes it; payload stays put while valid
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (out_valid) begin
      if (out_ready) out_valid <= 1'b0;
    end else if (in_valid) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end
endmodule

// File: rtl/rom_load_sched.sv
// rom_load_sched: ioctl download scheduler to ROM write port; ROM_LOAD_CHECKSUM_EN adds checksum output
module rom_load_sched
  import rom_load_pkg::*;
#(
  parameter logic [24:0] R0_END   = R0_END_DEF,
  parameter logic [24:0] R1_END   = R1_END_DEF,
  parameter logic [24:0] R2_END   = R2_END_DEF,
  parameter int          RST_HOLD = 16
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        rom_wr,
  output logic [1:0]  rom_sel,
  output logic [15:0] rom_addr,
  output logic [7:0]  rom_data,
  input  logic        rom_ready,
  output logic [7:0]  mod,
  output logic [63:0] dip,
  output logic        board_reset,
  output logic        load_err
`ifdef ROM_LOAD_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);
  load_state_t state, nxt;
  logic [7:0] cnt;
  logic full, start, clear, rom_byte, in_range, accept, rom_err;
  rom_region_t sel;
  logic [24:0] base;
  logic [15:0] off;
  logic [25:0] payload;

  assign start    = ioctl_download && ioctl_index == IDX_ROM;
  assign clear    = start && (state == IDLE || state == HOLD);
  assign sel      = ioctl_addr < R0_END ? REG_CPU : ioctl_addr < R1_END ? REG_SND : REG_GFX;
  assign base     = sel == REG_CPU ? 25'd0 : sel == REG_SND ? R0_END : R1_END;
  assign off      = 16'(ioctl_addr - base);
  assign in_range = ioctl_addr < R2_END;
  assign rom_byte = ioctl_wr && ioctl_index == IDX_ROM;
  assign accept   = rom_byte && in_range && !full;
  assign rom_err  = rom_byte && (!in_range || full);

  rom_load_skid #(.W(26)) u_skid (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .in_valid (accept),
    .in_data  ({sel, off, ioctl_dout}),
    .out_ready(rom_ready),
    .out_valid(full),
    .out_data (payload)
  );

  assign rom_wr     = full;
  assign ioctl_wait = full;
  assign rom_sel    = payload[25:24];
  assign rom_addr   = payload[23:8];
  assign rom_data   = payload[7:0];

  // next state: hold boards in reset from load start until the tail expires
  always_comb begin
    nxt = state;
    board_reset = state != IDLE;
    nxt = state == IDLE  ? (start ? LOAD : IDLE)
        : state == LOAD  ? (ioctl_download ? LOAD : full ? DRAIN : HOLD)
        : state == DRAIN ? ((!full || rom_ready) ? HOLD : DRAIN)
        : (start ? LOAD : cnt == 8'(RST_HOLD - 1) ? IDLE : HOLD);
  end

  // state register and reset-tail counter; power-up starts in the tail
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      state <= HOLD;
      cnt   <= 8'd0;
    end else begin
      state <= nxt;
      cnt   <= (state == HOLD && nxt == HOLD) ? cnt + 8'd1 : 8'd0;
    end

  // sticky error plus mode and DIP capture from their download indices
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      load_err <= 1'b0;
      mod      <= 8'hFF;
      dip      <= 64'd0;
    end else begin
      load_err <= (clear ? 1'b0 : load_err) | rom_err;
      if (ioctl_wr && ioctl_index == IDX_MOD) mod <= ioctl_dout;
      if (ioctl_wr && ioctl_index == IDX_DIP && ioctl_addr[24:3] == 22'd0)
        dip[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
    end

`ifdef ROM_LOAD_CHECKSUM_EN
  // wrapping sum of every ROM byte taken into the buffer during this load
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) checksum <= 16'd0;
    else if (clear) checksum <= 16'd0;
    else if (accept) checksum <= checksum + {8'd0, ioctl_dout};
`endif
endmodule

// File: tb/tb_rom_load_sched.sv
// tb_rom_load_sched: table-driven directed bench for rom_load_sched
module tb_rom_load_sched;
  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download, ioctl_wr, rom_ready;
  logic [7:0]  ioctl_index, ioctl_dout;
  logic [24:0] ioctl_addr;
  logic        ioctl_wait, rom_wr, board_reset, load_err;
  logic [1:0]  rom_sel;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data, mod;
  logic [63:0] dip;
`ifdef ROM_LOAD_CHECKSUM_EN
  logic [15:0] checksum;
`endif
  int errors = 0, checks = 0, nwr = 0;

  rom_load_sched dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .rom_wr(rom_wr),
    .rom_sel(rom_sel), .rom_addr(rom_addr), .rom_data(rom_data),
    .rom_ready(rom_ready), .mod(mod), .dip(dip), .board_reset(board_reset),
    .load_err(load_err)
`ifdef ROM_LOAD_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) if (rom_wr && rom_ready) nwr <= nwr + 1;

  typedef struct {
    logic dl, wr; logic [7:0] idx; logic [24:0] addr; logic [7:0] dout; logic rdy;
    logic e_wr; logic [1:0] e_sel; logic [15:0] e_addr; logic [7:0] e_data; logic e_err, e_br;
  } vec_t;
  vec_t v[22];

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic dl, input logic wr, input logic [7:0] idx,
                       input logic [24:0] addr, input logic [7:0] dout, input logic rdy);
    ioctl_download = dl; ioctl_wr = wr; ioctl_index = idx;
    ioctl_addr = addr; ioctl_dout = dout; rom_ready = rdy;
  endtask

  task automatic tail(input string name);
    int n = 0;
    for (int i = 0; i < 40 && board_reset; i++) begin
      step();
      n++;
    end
    chk(name, 64'(n), 64'd16);
  endtask

  initial begin
    v[0]  = '{1,0,0,25'h0,    8'h00,1, 0,0,16'h0000,8'h00,0,1};
    v[1]  = '{1,1,0,25'h0,    8'h11,1, 1,0,16'h0000,8'h11,0,1};
    v[2]  = '{1,0,0,25'h0,    8'h00,1, 0,0,16'h0000,8'h11,0,1};
    v[3]  = '{1,1,0,25'hC000, 8'h22,1, 1,1,16'h0000,8'h22,0,1};
    v[4]  = '{1,0,0,25'h0,    8'h00,1, 0,1,16'h0000,8'h22,0,1};
    v[5]  = '{1,1,0,25'h14FFF,8'h33,1, 1,2,16'h7FFF,8'h33,0,1};
    v[6]  = '{1,0,0,25'h0,    8'h00,1, 0,2,16'h7FFF,8'h33,0,1};
    v[7]  = '{1,1,0,25'h15000,8'h44,1, 0,2,16'h7FFF,8'h33,1,1};
    v[8]  = '{1,0,0,25'h0,    8'h00,1, 0,2,16'h7FFF,8'h33,1,1};
    v[9]  = '{1,1,0,25'h10,   8'h55,0, 1,0,16'h0010,8'h55,1,1};
    for (int i = 10; i < 15; i++) v[i] = '{1,0,0,25'h0,8'h00,0, 1,0,16'h0010,8'h55,1,1};
    v[15] = '{1,0,0,25'h0,    8'h00,1, 0,0,16'h0010,8'h55,1,1};
    v[16] = '{0,0,0,25'h0,    8'h00,1, 0,0,16'h0010,8'h55,1,1};
    v[17] = '{1,0,0,25'h0,    8'h00,1, 0,0,16'h0010,8'h55,0,1};
    v[18] = '{1,1,0,25'h20,   8'h66,0, 1,0,16'h0020,8'h66,0,1};
    v[19] = '{1,1,0,25'h21,   8'h77,0, 1,0,16'h0020,8'h66,1,1};
    v[20] = '{0,0,0,25'h0,    8'h00,0, 1,0,16'h0020,8'h66,1,1};
    v[21] = '{0,0,0,25'h0,    8'h00,1, 0,0,16'h0020,8'h66,1,1};

    reset_n = 1'b0;
    drive(0, 0, 8'd0, 25'd0, 8'd0, 1'b1);
    step(); step();
    chk("rst_rom_wr", 64'(rom_wr), 64'd0);
    chk("rst_wait", 64'(ioctl_wait), 64'd0);
    chk("rst_board_reset", 64'(board_reset), 64'd1);
    chk("rst_mod", 64'(mod), 64'hFF);
    chk("rst_dip", dip, 64'd0);
    chk("rst_load_err", 64'(load_err), 64'd0);
    chk("rst_payload", 64'({rom_sel, rom_addr, rom_data}), 64'd0);
    reset_n = 1'b1;
    tail("powerup_tail");

    for (int i = 0; i < 22; i++) begin
      drive(v[i].dl, v[i].wr, v[i].idx, v[i].addr, v[i].dout, v[i].rdy);
      step();
      chk($sformatf("v%0d_rom_wr", i), 64'(rom_wr), 64'(v[i].e_wr));
      chk($sformatf("v%0d_wait", i), 64'(ioctl_wait), 64'(v[i].e_wr));
      chk($sformatf("v%0d_sel", i), 64'(rom_sel), 64'(v[i].e_sel));
      chk($sformatf("v%0d_addr", i), 64'(rom_addr), 64'(v[i].e_addr));
      chk($sformatf("v%0d_data", i), 64'(rom_data), 64'(v[i].e_data));
      chk($sformatf("v%0d_err", i), 64'(load_err), 64'(v[i].e_err));
      chk($sformatf("v%0d_board_reset", i), 64'(board_reset), 64'(v[i].e_br));
    end
`ifdef ROM_LOAD_CHECKSUM_EN
    chk("checksum", 64'(checksum), 64'h66);
`endif
    tail("drain_tail");
    chk("write_count", 64'(nwr), 64'd5);

    drive(1, 1, 8'd1, 25'd5, 8'h3C, 1'b1);
    step();
    chk("mod_value", 64'(mod), 64'h3C);
    drive(1, 1, 8'd254, 25'd3, 8'h5A, 1'b1);
    step();
    drive(1, 1, 8'd254, 25'd8, 8'h77, 1'b1);
    step();
    drive(0, 0, 8'd0, 25'd0, 8'd0, 1'b1);
    step();
    chk("dip_byte3", 64'(dip[31:24]), 64'h5A);
    chk("dip_all", dip, 64'h5A00_0000);
    chk("dip_board_reset", 64'(board_reset), 64'd0);
    chk("dip_wait", 64'(ioctl_wait), 64'd0);

    drive(1, 0, 8'd0, 25'd0, 8'd0, 1'b0);
    step();
    drive(1, 1, 8'd0, 25'd5, 8'h99, 1'b0);
    step();
    drive(1, 0, 8'd0, 25'd0, 8'd0, 1'b0);
    chk("pre_async_rom_wr", 64'(rom_wr), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rom_wr", 64'(rom_wr), 64'd0);
    chk("async_wait", 64'(ioctl_wait), 64'd0);
    chk("async_board_reset", 64'(board_reset), 64'd1);
    chk("async_mod", 64'(mod), 64'hFF);
    chk("async_dip", dip, 64'd0);
    drive(0, 0, 8'd0, 25'd0, 8'd0, 1'b1);
    step();
    reset_n = 1'b1;
    tail("async_tail");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
